// File: rtl/ch0re_run_ctrl.sv
// ch0re_run_ctrl: run controller for the ch0re 5-stage pipeline.
//
// Sequences the core reset, counts RUN cycles and retired instructions,
// and detects termination:
//   - a tohost store with bit 0 set
//   - a halt request
//   - a cycle-limit timeout
// Status outputs are registered or decoded from the FSM state register,
// so no input reaches an output combinationally.
//
// Optional feature (compile-time macro CH0RE_RUN_CTRL_WDOG_EN):
//   Retire watchdog. It ends the run when WDOG_CYCLES consecutive RUN
//   cycles retire nothing. It adds the output port wdog_trip.

module ch0re_run_ctrl #(
   parameter int unsigned RST_CYCLES  = 4,
   parameter int unsigned MAX_CYCLES  = 10000,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned RETIRE_W    = 1,
   parameter int unsigned WDOG_CYCLES = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                core_rst_n,
   input  logic [RETIRE_W-1:0] retire_vld,
   input  logic                halt_req,
   input  logic                tohost_we,
   input  logic [31:0]         tohost_data,
   output logic                running,
   output logic                done,
   output logic                pass,
   output logic                timeout,
   output logic [30:0]         exit_code,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    retire_cnt
`ifdef CH0RE_RUN_CTRL_WDOG_EN
   ,
   output logic                wdog_trip
`endif
);

   // Elaboration-time sanity checks on the configuration
   if (RST_CYCLES < 1) begin : g_chk_rst_cycles
      $error("ch0re_run_ctrl: RST_CYCLES must be at least 1");
   end
   if ((RETIRE_W < 1) || (RETIRE_W > 4)) begin : g_chk_retire_w
      $error("ch0re_run_ctrl: RETIRE_W must be in 1..4");
   end
   if (WDOG_CYCLES < 1) begin : g_chk_wdog_cycles
      $error("ch0re_run_ctrl: WDOG_CYCLES must be at least 1");
   end

   // FSM encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RESET = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Reset-hold counter counts RST_CYCLES-1 down to 0
   localparam int unsigned      RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_CYCLES - 1);

   // Value of cycle_cnt (before increment) on the last permitted RUN edge
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MAX_CYCLES - 1);

   // Reserved exit codes for controller-detected terminations
   localparam logic [30:0] CODE_TIMEOUT = 31'h7FFF_FFFF;
   localparam logic [30:0] CODE_WDOG    = 31'h7FFF_FFFE;

   // Number of lanes retiring this cycle, widened to counter width
   function automatic logic [CNT_W-1:0] popcount(input logic [RETIRE_W-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < RETIRE_W; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   // Unsigned add that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   logic [1:0]       state;
   logic [RC_W-1:0]  rst_ctr;

   logic             start_ok;
   logic             run_entry;
   logic             in_run;
   logic [CNT_W-1:0] cycle_nxt;
   logic [CNT_W-1:0] retire_nxt;
   logic             exit_hit;
   logic             tmo_hit;
   logic             wdog_hit;
   logic             term;

`ifdef CH0RE_RUN_CTRL_WDOG_EN
   localparam int unsigned     WD_W      = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYCLES - 1);
   logic [WD_W-1:0] wdog_cnt;
   logic            no_retire;
`endif

   assign running = (state == S_RUN);
   assign done    = (state == S_DONE);

   // Decode of this edge's start acceptance, RUN entry, counter updates and termination
   always_comb begin
      start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
      run_entry  = (state == S_RESET) && (rst_ctr == '0);
      in_run     = (state == S_RUN);
      cycle_nxt  = sat_add(cycle_cnt, CNT_W'(1));
      retire_nxt = sat_add(retire_cnt, popcount(retire_vld));
      exit_hit   = tohost_we && tohost_data[0];
      tmo_hit    = (MAX_CYCLES != 0) && (cycle_cnt == TMO_LAST);
      wdog_hit   = 1'b0;
`ifdef CH0RE_RUN_CTRL_WDOG_EN
      no_retire  = (retire_vld == '0);
      wdog_hit   = no_retire && (wdog_cnt == WDOG_LAST);
`endif
      term       = in_run && (exit_hit || halt_req || tmo_hit || wdog_hit);
   end

   // FSM, reset-hold counter and the registered core reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rst_ctr    <= '0;
         core_rst_n <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               core_rst_n <= 1'b0;
               if (start_ok) begin
                  state   <= S_RESET;
                  rst_ctr <= RC_LOAD;
               end
            end
            S_RESET: begin
               if (run_entry) begin
                  state      <= S_RUN;
                  core_rst_n <= 1'b1;
               end else begin
                  rst_ctr <= rst_ctr - RC_W'(1);
               end
            end
            S_RUN: begin
               if (term) begin
                  state      <= S_DONE;
                  core_rst_n <= 1'b0;
               end
            end
            default: begin
               state      <= S_IDLE;
               core_rst_n <= 1'b0;
            end
         endcase
      end
   end

   // Cycle and retire counters: cleared on start, advanced on every RUN edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else if (start_ok) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else if (in_run) begin
         cycle_cnt  <= cycle_nxt;
         retire_cnt <= retire_nxt;
      end
   end

   // Termination status: tohost beats halt, halt beats timeout, timeout beats watchdog
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass      <= 1'b0;
         timeout   <= 1'b0;
         exit_code <= '0;
      end else if (start_ok) begin
         pass      <= 1'b0;
         timeout   <= 1'b0;
         exit_code <= '0;
      end else if (in_run) begin
         if (exit_hit) begin
            exit_code <= tohost_data[31:1];
            pass      <= (tohost_data[31:1] == 31'd0);
         end else if (halt_req) begin
            exit_code <= 31'd0;
            pass      <= 1'b1;
         end else if (tmo_hit) begin
            exit_code <= CODE_TIMEOUT;
            pass      <= 1'b0;
            timeout   <= 1'b1;
         end else if (wdog_hit) begin
            exit_code <= CODE_WDOG;
            pass      <= 1'b0;
         end
      end
   end

`ifdef CH0RE_RUN_CTRL_WDOG_EN
   // Watchdog: counts consecutive non-retiring RUN cycles, flags a trip when it wins priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt  <= '0;
         wdog_trip <= 1'b0;
      end else if (start_ok) begin
         wdog_cnt  <= '0;
         wdog_trip <= 1'b0;
      end else if (run_entry) begin
         wdog_cnt  <= '0;
      end else if (in_run) begin
         if (!no_retire) begin
            wdog_cnt <= '0;
         end else if (!wdog_hit) begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
         end
         if (wdog_hit && !exit_hit && !halt_req && !tmo_hit) begin
            wdog_trip <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ch0re_run_ctrl.sv
// Directed testbench for ch0re_run_ctrl.
// DUT configuration: RST_CYCLES=4, MAX_CYCLES=20, RETIRE_W=2, WDOG_CYCLES=8.
// Any run that lasts 8 or more cycles keeps a lane retiring, so the
// watchdog (when compiled in) cannot trip outside its own test.

module tb_ch0re_run_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        core_rst_n;
   logic [1:0]  retire_vld;
   logic        halt_req;
   logic        tohost_we;
   logic [31:0] tohost_data;
   logic        running;
   logic        done;
   logic        pass;
   logic        timeout;
   logic [30:0] exit_code;
   logic [31:0] cycle_cnt;
   logic [31:0] retire_cnt;
`ifdef CH0RE_RUN_CTRL_WDOG_EN
   logic        wdog_trip;
`endif

   int checks   = 0;
   int failures = 0;

   ch0re_run_ctrl #(
      .RST_CYCLES (4),
      .MAX_CYCLES (20),
      .CNT_W      (32),
      .RETIRE_W   (2),
      .WDOG_CYCLES(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .core_rst_n (core_rst_n),
      .retire_vld (retire_vld),
      .halt_req   (halt_req),
      .tohost_we  (tohost_we),
      .tohost_data(tohost_data),
      .running    (running),
      .done       (done),
      .pass       (pass),
      .timeout    (timeout),
      .exit_code  (exit_code),
      .cycle_cnt  (cycle_cnt),
      .retire_cnt (retire_cnt)
`ifdef CH0RE_RUN_CTRL_WDOG_EN
      ,
      .wdog_trip  (wdog_trip)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start       = 1'b0;
      retire_vld  = 2'b00;
      halt_req    = 1'b0;
      tohost_we   = 1'b0;
      tohost_data = 32'h0;
   endtask

   task automatic hard_reset();
      step();
      clear_inputs();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic start_run();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
   endtask

   // Start sequence: start sampled at edge 0, core_rst_n rises after edge 4
   task automatic test_rst_seq(input string tag);
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL %s_e0_core_rst_n got=%0b exp=0", tag, core_rst_n); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL %s_e0_running got=%0b exp=0", tag, running); end
      step();
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL %s_e1_core_rst_n got=%0b exp=0", tag, core_rst_n); end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL %s_e2_core_rst_n got=%0b exp=0", tag, core_rst_n); end
      step();
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL %s_e3_core_rst_n got=%0b exp=0", tag, core_rst_n); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL %s_e3_running got=%0b exp=0", tag, running); end
      step();
      checks++; if (core_rst_n !== 1'b1) begin failures++; $display("FAIL %s_e4_core_rst_n got=%0b exp=1", tag, core_rst_n); end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL %s_e4_running got=%0b exp=1", tag, running); end
      checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL %s_e4_cycle_cnt got=%0d exp=0", tag, cycle_cnt); end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      #12;
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL reset_core_rst_n got=%0b exp=0", core_rst_n); end
      checks++; if ({running, done, pass, timeout} !== 4'b0000) begin failures++; $display("FAIL reset_status got=%b exp=0000", {running, done, pass, timeout}); end
      checks++; if (exit_code !== 31'd0) begin failures++; $display("FAIL reset_exit_code got=%0h exp=0", exit_code); end
      checks++; if ({cycle_cnt, retire_cnt} !== 64'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_cnt, retire_cnt); end
      rst_n = 1'b1;
      step();
      step();
      checks++; if ({running, done, core_rst_n} !== 3'b000) begin failures++; $display("FAIL idle_hold got=%b exp=000", {running, done, core_rst_n}); end
      test_rst_seq("rstseq");
   endtask

   task automatic test_pass_exit();
      hard_reset();
      start_run();
      retire_vld = 2'b11;
      repeat (3) step();
      retire_vld  = 2'b00;
      tohost_we   = 1'b1;
      tohost_data = 32'h1;
      step();
      tohost_we   = 1'b0;
      tohost_data = 32'h0;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL pass_done got=%0b exp=1", done); end
      checks++; if (pass !== 1'b1) begin failures++; $display("FAIL pass_pass got=%0b exp=1", pass); end
      checks++; if (exit_code !== 31'd0) begin failures++; $display("FAIL pass_exit_code got=%0h exp=0", exit_code); end
      checks++; if (retire_cnt !== 32'd6) begin failures++; $display("FAIL pass_retire_cnt got=%0d exp=6", retire_cnt); end
      checks++; if (cycle_cnt !== 32'd4) begin failures++; $display("FAIL pass_cycle_cnt got=%0d exp=4", cycle_cnt); end
      checks++; if ({core_rst_n, running, timeout} !== 3'b000) begin failures++; $display("FAIL pass_ctrl got=%b exp=000", {core_rst_n, running, timeout}); end
      // DONE is frozen against further activity
      retire_vld = 2'b11;
      halt_req   = 1'b1;
      repeat (3) step();
      retire_vld = 2'b00;
      halt_req   = 1'b0;
      checks++; if ({cycle_cnt, retire_cnt} !== {32'd4, 32'd6}) begin failures++; $display("FAIL done_frozen got=%0d/%0d exp=4/6", cycle_cnt, retire_cnt); end
      checks++; if ({done, pass} !== 2'b11) begin failures++; $display("FAIL done_frozen_status got=%b exp=11", {done, pass}); end
   endtask

   task automatic test_fail_collision();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if ({done, pass} !== 2'b00) begin failures++; $display("FAIL restart_clear_status got=%b exp=00", {done, pass}); end
      checks++; if ({cycle_cnt, retire_cnt} !== 64'd0) begin failures++; $display("FAIL restart_clear_cnt got=%0d/%0d exp=0/0", cycle_cnt, retire_cnt); end
      repeat (4) step();
      retire_vld = 2'b01;
      step();
      retire_vld  = 2'b00;
      tohost_we   = 1'b1;
      tohost_data = 32'h7;
      halt_req    = 1'b1;
      step();
      clear_inputs();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL coll_done got=%0b exp=1", done); end
      checks++; if (pass !== 1'b0) begin failures++; $display("FAIL coll_pass got=%0b exp=0", pass); end
      checks++; if (exit_code !== 31'd3) begin failures++; $display("FAIL coll_exit_code got=%0h exp=3", exit_code); end
      checks++; if ({cycle_cnt, retire_cnt} !== {32'd2, 32'd1}) begin failures++; $display("FAIL coll_counters got=%0d/%0d exp=2/1", cycle_cnt, retire_cnt); end
   endtask

   task automatic test_halt();
      start_run();
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      checks++; if ({done, pass, timeout} !== 3'b110) begin failures++; $display("FAIL halt_status got=%b exp=110", {done, pass, timeout}); end
      checks++; if (exit_code !== 31'd0) begin failures++; $display("FAIL halt_exit_code got=%0h exp=0", exit_code); end
      checks++; if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL halt_cycle_cnt got=%0d exp=1", cycle_cnt); end
   endtask

   task automatic test_timeout();
      start_run();
      retire_vld = 2'b01;
      repeat (19) step();
      checks++; if ({done, timeout} !== 2'b00) begin failures++; $display("FAIL tmo_early got=%b exp=00", {done, timeout}); end
      checks++; if (cycle_cnt !== 32'd19) begin failures++; $display("FAIL tmo_early_cnt got=%0d exp=19", cycle_cnt); end
      step();
      retire_vld = 2'b00;
      checks++; if ({done, timeout, pass} !== 3'b110) begin failures++; $display("FAIL tmo_status got=%b exp=110", {done, timeout, pass}); end
      checks++; if (exit_code !== 31'h7FFF_FFFF) begin failures++; $display("FAIL tmo_exit_code got=%0h exp=7fffffff", exit_code); end
      checks++; if ({cycle_cnt, retire_cnt} !== {32'd20, 32'd20}) begin failures++; $display("FAIL tmo_counters got=%0d/%0d exp=20/20", cycle_cnt, retire_cnt); end
      checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL tmo_core_rst_n got=%0b exp=0", core_rst_n); end
   endtask

   task automatic test_async_reset();
      start_run();
      retire_vld  = 2'b01;
      tohost_we   = 1'b1;
      tohost_data = 32'h2;
      step();
      step();
      start = 1'b1;
      step();
      start     = 1'b0;
      tohost_we = 1'b0;
      checks++; if ({running, done} !== 2'b10) begin failures++; $display("FAIL ignore_start_console got=%b exp=10", {running, done}); end
      checks++; if ({cycle_cnt, retire_cnt} !== {32'd3, 32'd3}) begin failures++; $display("FAIL ignore_counters got=%0d/%0d exp=3/3", cycle_cnt, retire_cnt); end
      repeat (4) step();
      checks++; if (cycle_cnt !== 32'd7) begin failures++; $display("FAIL midrun_cycle_cnt got=%0d exp=7", cycle_cnt); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({core_rst_n, running, done, pass, timeout} !== 5'b00000) begin failures++; $display("FAIL async_status got=%b exp=00000", {core_rst_n, running, done, pass, timeout}); end
      checks++; if ({cycle_cnt, retire_cnt} !== 64'd0) begin failures++; $display("FAIL async_counters got=%0d/%0d exp=0/0", cycle_cnt, retire_cnt); end
      checks++; if (exit_code !== 31'd0) begin failures++; $display("FAIL async_exit_code got=%0h exp=0", exit_code); end
      #1;
      rst_n = 1'b1;
      clear_inputs();
      test_rst_seq("rerun");
   endtask

`ifdef CH0RE_RUN_CTRL_WDOG_EN
   task automatic test_wdog();
      hard_reset();
      start_run();
      repeat (7) step();
      checks++; if ({done, wdog_trip} !== 2'b00) begin failures++; $display("FAIL wdog_early got=%b exp=00", {done, wdog_trip}); end
      step();
      checks++; if ({done, wdog_trip, pass, timeout} !== 4'b1100) begin failures++; $display("FAIL wdog_status got=%b exp=1100", {done, wdog_trip, pass, timeout}); end
      checks++; if (exit_code !== 31'h7FFF_FFFE) begin failures++; $display("FAIL wdog_exit_code got=%0h exp=7ffffffe", exit_code); end
      checks++; if (cycle_cnt !== 32'd8) begin failures++; $display("FAIL wdog_cycle_cnt got=%0d exp=8", cycle_cnt); end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (wdog_trip !== 1'b0) begin failures++; $display("FAIL wdog_clear got=%0b exp=0", wdog_trip); end
      repeat (4) step();
      repeat (4) step();
      retire_vld = 2'b01;
      step();
      retire_vld = 2'b00;
      repeat (7) step();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL wdog_delay_early got=%0b exp=0", done); end
      step();
      checks++; if ({done, wdog_trip} !== 2'b11) begin failures++; $display("FAIL wdog_delay_trip got=%b exp=11", {done, wdog_trip}); end
      checks++; if ({cycle_cnt, retire_cnt} !== {32'd13, 32'd1}) begin failures++; $display("FAIL wdog_delay_counters got=%0d/%0d exp=13/1", cycle_cnt, retire_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_pass_exit();
      test_fail_collision();
      test_halt();
      test_timeout();
      test_async_reset();
`ifdef CH0RE_RUN_CTRL_WDOG_EN
      test_wdog();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
